// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg
// Shared types and encodings for the multi-cycle MIPS control unit:
//   - state_t  : FSM state codes (also exported on the debug `state` port)
//   - iclass_t : instruction class produced by mc_decode, held in the class register
//   - opcode / funct constants of the supported instructions
//   - mux-select encodings for npc_sel, reg_dst, wd_sel and alu_op
//   - alu_ctl_for(): ALU-side selects for a class, shared by EXEC/MEM/WB so the
//     ALU inputs stay stable for as long as the instruction needs its result
package mc_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_TRAP   = 3'd5
   } state_t;

   typedef enum logic [3:0] {
      CL_NOP     = 4'd0,
      CL_ADDU    = 4'd1,
      CL_SUBU    = 4'd2,
      CL_JR      = 4'd3,
      CL_ORI     = 4'd4,
      CL_LUI     = 4'd5,
      CL_LW      = 4'd6,
      CL_SW      = 4'd7,
      CL_BEQ     = 4'd8,
      CL_JAL     = 4'd9,
      CL_ILLEGAL = 4'd10
   } iclass_t;

   // Opcodes (IR[31:26])
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_JAL   = 6'b000011;

   // R-type funct codes (IR[5:0])
   localparam logic [5:0] FN_NOP  = 6'b000000;
   localparam logic [5:0] FN_JR   = 6'b001000;
   localparam logic [5:0] FN_ADDU = 6'b100001;
   localparam logic [5:0] FN_SUBU = 6'b100011;

   // Next-PC select
   localparam logic [1:0] NPC_PC4    = 2'd0;
   localparam logic [1:0] NPC_BRANCH = 2'd1;
   localparam logic [1:0] NPC_JUMP   = 2'd2;
   localparam logic [1:0] NPC_REG    = 2'd3;

   // Register-file destination select
   localparam logic [1:0] DST_RT = 2'd0;
   localparam logic [1:0] DST_RD = 2'd1;
   localparam logic [1:0] DST_RA = 2'd2;

   // Register-file write-data select
   localparam logic [1:0] WD_ALU = 2'd0;
   localparam logic [1:0] WD_MEM = 2'd1;
   localparam logic [1:0] WD_PC4 = 2'd2;

   // ALU operation
   localparam logic [1:0] ALU_ADD = 2'd0;
   localparam logic [1:0] ALU_SUB = 2'd1;
   localparam logic [1:0] ALU_OR  = 2'd2;
   localparam logic [1:0] ALU_LUI = 2'd3;

   typedef struct packed {
      logic       alu_src;
      logic       ext_op;
      logic [1:0] alu_op;
   } alu_ctl_t;

   function automatic alu_ctl_t alu_ctl_for(input iclass_t c);
      alu_ctl_t a;
      a = '0;
      case (c)
         CL_ADDU: a.alu_op = ALU_ADD;
         CL_SUBU: a.alu_op = ALU_SUB;
         CL_ORI: begin
            a.alu_src = 1'b1;
            a.alu_op  = ALU_OR;
         end
         CL_LUI: begin
            a.alu_src = 1'b1;
            a.alu_op  = ALU_LUI;
         end
         CL_LW, CL_SW: begin
            a.alu_src = 1'b1;
            a.ext_op  = 1'b1;
            a.alu_op  = ALU_ADD;
         end
         CL_BEQ: begin
            // rs - rt compare; EXT sign-extends the offset for the branch target
            a.ext_op = 1'b1;
            a.alu_op = ALU_SUB;
         end
         default: a = '0;
      endcase
      return a;
   endfunction

endpackage

// File: rtl/mc_decode.sv
// mc_decode
// Purely combinational instruction classifier, kept free of state so a later
// pipelined decoder can reuse it as-is.
// Ports:
//   opcode  in  6 : IR[31:26]
//   funct   in  6 : IR[5:0] (only meaningful for R-type)
//   iclass  out 4 : instruction class (iclass_t), CL_ILLEGAL for anything unsupported
module mc_decode
   import mc_ctrl_pkg::*;
(
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   output iclass_t    iclass
);

   always_comb begin
      iclass = CL_ILLEGAL;
      case (opcode)
         OP_RTYPE: begin
            case (funct)
               FN_ADDU: iclass = CL_ADDU;
               FN_SUBU: iclass = CL_SUBU;
               FN_JR:   iclass = CL_JR;
               FN_NOP:  iclass = CL_NOP;
               default: iclass = CL_ILLEGAL;
            endcase
         end
         OP_ORI:  iclass = CL_ORI;
         OP_LUI:  iclass = CL_LUI;
         OP_LW:   iclass = CL_LW;
         OP_SW:   iclass = CL_SW;
         OP_BEQ:  iclass = CL_BEQ;
         OP_JAL:  iclass = CL_JAL;
         default: iclass = CL_ILLEGAL;
      endcase
   end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl
// Multi-cycle control FSM for the MIPS core. Sequences one shared datapath
// through FETCH / DECODE / EXEC / MEM / WB, traps on unsupported instructions,
// and counts retired instructions.
// Ports:
//   clk          in   1 : core clock, rising edge
//   reset        in   1 : synchronous reset, active-low
//   opcode       in   6 : IR[31:26]
//   funct        in   6 : IR[5:0]
//   zero         in   1 : ALU result == 0
//   mem_ack      in   1 : memory completed the current request this cycle
//   mem_req      out  1 : memory request, held until mem_ack
//   mem_we       out  1 : memory write qualifier (sw)
//   pc_en        out  1 : PC load
//   npc_sel      out  2 : next-PC select
//   ir_en        out  1 : IR load
//   reg_we       out  1 : register file write
//   reg_dst      out  2 : destination register select
//   wd_sel       out  2 : write-data select
//   alu_src      out  1 : ALU B operand select (0 = GPR[rt], 1 = EXT)
//   ext_op       out  1 : 0 = zero-extend, 1 = sign-extend
//   alu_op       out  2 : ALU operation
//   illegal      out  1 : core is in TRAP
//   state        out  3 : current state code (debug)
//   instr_count  out 32 : retired instruction count (wraps)
module mc_ctrl
   import mc_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic [5:0]  opcode,
   input  logic [5:0]  funct,
   input  logic        zero,
   input  logic        mem_ack,
   output logic        mem_req,
   output logic        mem_we,
   output logic        pc_en,
   output logic [1:0]  npc_sel,
   output logic        ir_en,
   output logic        reg_we,
   output logic [1:0]  reg_dst,
   output logic [1:0]  wd_sel,
   output logic        alu_src,
   output logic        ext_op,
   output logic [1:0]  alu_op,
   output logic        illegal,
   output logic [2:0]  state,
   output logic [31:0] instr_count
);

   state_t      state_q, state_d;
   iclass_t     class_q;
   iclass_t     dec_class;
   logic [31:0] count_q;
   logic        retire;
   alu_ctl_t    alu_held;

   // Raw (pre-reset-gating) control outputs
   logic       mem_req_c, mem_we_c, pc_en_c, ir_en_c, reg_we_c, illegal_c;
   logic [1:0] npc_sel_c, reg_dst_c, wd_sel_c;
   alu_ctl_t   alu_c;

   mc_decode u_decode (
      .opcode (opcode),
      .funct  (funct),
      .iclass (dec_class)
   );

   assign alu_held = alu_ctl_for(class_q);

   // ---- state / class / retire registers ----
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= ST_FETCH;
         class_q <= CL_NOP;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == ST_DECODE) class_q <= dec_class;
         if (retire)               count_q <= count_q + 32'd1;
      end
   end

   // ---- next state and control decode ----
   always_comb begin
      state_d   = state_q;
      retire    = 1'b0;
      mem_req_c = 1'b0;
      mem_we_c  = 1'b0;
      pc_en_c   = 1'b0;
      npc_sel_c = NPC_PC4;
      ir_en_c   = 1'b0;
      reg_we_c  = 1'b0;
      reg_dst_c = DST_RT;
      wd_sel_c  = WD_ALU;
      alu_c     = '0;
      illegal_c = 1'b0;

      case (state_q)
         ST_FETCH: begin
            mem_req_c = 1'b1;
            if (mem_ack) begin
               ir_en_c   = 1'b1;
               pc_en_c   = 1'b1;
               npc_sel_c = NPC_PC4;
               state_d   = ST_DECODE;
            end
         end

         ST_DECODE: begin
            // Transition uses the live decode; the class register captures it on this edge.
            case (dec_class)
               CL_NOP: begin
                  retire  = 1'b1;
                  state_d = ST_FETCH;
               end
               CL_ILLEGAL: state_d = ST_TRAP;
               default:    state_d = ST_EXEC;
            endcase
         end

         ST_EXEC: begin
            alu_c = alu_held;
            case (class_q)
               CL_ADDU, CL_SUBU, CL_ORI, CL_LUI: state_d = ST_WB;
               CL_LW, CL_SW:                     state_d = ST_MEM;
               CL_BEQ: begin
                  npc_sel_c = NPC_BRANCH;
                  pc_en_c   = zero;
                  retire    = 1'b1;
                  state_d   = ST_FETCH;
               end
               CL_JAL: begin
                  pc_en_c   = 1'b1;
                  npc_sel_c = NPC_JUMP;
                  reg_we_c  = 1'b1;
                  reg_dst_c = DST_RA;
                  wd_sel_c  = WD_PC4;
                  retire    = 1'b1;
                  state_d   = ST_FETCH;
               end
               CL_JR: begin
                  pc_en_c   = 1'b1;
                  npc_sel_c = NPC_REG;
                  retire    = 1'b1;
                  state_d   = ST_FETCH;
               end
               // NOP/ILLEGAL never reach EXEC; treat a corrupted class as a trap.
               default: state_d = ST_TRAP;
            endcase
         end

         ST_MEM: begin
            // ALU keeps computing the address: there is no address register in the datapath.
            alu_c     = alu_held;
            mem_req_c = 1'b1;
            mem_we_c  = (class_q == CL_SW);
            if (mem_ack) begin
               if (class_q == CL_SW) begin
                  retire  = 1'b1;
                  state_d = ST_FETCH;
               end else begin
                  state_d = ST_WB;
               end
            end
         end

         ST_WB: begin
            alu_c    = alu_held;
            reg_we_c = 1'b1;
            case (class_q)
               CL_ADDU, CL_SUBU: begin
                  reg_dst_c = DST_RD;
                  wd_sel_c  = WD_ALU;
               end
               CL_LW: begin
                  reg_dst_c = DST_RT;
                  wd_sel_c  = WD_MEM;
               end
               default: begin
                  reg_dst_c = DST_RT;
                  wd_sel_c  = WD_ALU;
               end
            endcase
            retire  = 1'b1;
            state_d = ST_FETCH;
         end

         ST_TRAP: illegal_c = 1'b1;

         default: state_d = ST_TRAP;
      endcase
   end

   // While reset is asserted every output is held quiet, so an aborted memory
   // write is withdrawn in the same cycle reset is applied.
   assign mem_req     = reset & mem_req_c;
   assign mem_we      = reset & mem_we_c;
   assign pc_en       = reset & pc_en_c;
   assign npc_sel     = reset ? npc_sel_c : 2'd0;
   assign ir_en       = reset & ir_en_c;
   assign reg_we      = reset & reg_we_c;
   assign reg_dst     = reset ? reg_dst_c : 2'd0;
   assign wd_sel      = reset ? wd_sel_c : 2'd0;
   assign alu_src     = reset & alu_c.alu_src;
   assign ext_op      = reset & alu_c.ext_op;
   assign alu_op      = reset ? alu_c.alu_op : 2'd0;
   assign illegal     = reset & illegal_c;
   assign state       = reset ? state_q : 3'd0;
   assign instr_count = reset ? count_q : 32'd0;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl
// Instruction-level reference model: each instruction is expanded into the
// sequence of cycles it must take (fetch waits, decode, exec, memory waits,
// write-back) with the control word expected in each, and the retire count
// advanced when the instruction finishes. Directed cases first, then a
// randomized instruction stream with random wait states, zero flags, traps
// and resets that abort in-flight memory accesses.
module tb_mc_ctrl;

   typedef struct packed {
      logic       mem_req;
      logic       mem_we;
      logic       pc_en;
      logic [1:0] npc_sel;
      logic       ir_en;
      logic       reg_we;
      logic [1:0] reg_dst;
      logic [1:0] wd_sel;
      logic       alu_src;
      logic       ext_op;
      logic [1:0] alu_op;
      logic       illegal;
      logic [2:0] state;
   } outs_t;

   localparam int K_NOP  = 0;
   localparam int K_ADDU = 1;
   localparam int K_SUBU = 2;
   localparam int K_JR   = 3;
   localparam int K_ORI  = 4;
   localparam int K_LUI  = 5;
   localparam int K_LW   = 6;
   localparam int K_SW   = 7;
   localparam int K_BEQ  = 8;
   localparam int K_JAL  = 9;
   localparam int K_ILL  = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic [5:0]  opcode, funct;
   logic        zero, mem_ack;
   logic        mem_req, mem_we, pc_en, ir_en, reg_we, alu_src, ext_op, illegal;
   logic [1:0]  npc_sel, reg_dst, wd_sel, alu_op;
   logic [2:0]  state;
   logic [31:0] instr_count;

   outs_t       obs;
   outs_t       full_mask, mem_mask;
   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] exp_count;
   int          cyc_n = 0;
   logic [5:0]  ill_op [6];
   logic [5:0]  ill_fn [6];

   always #5 clk = ~clk;

   mc_ctrl dut (
      .clk         (clk),
      .reset       (reset),
      .opcode      (opcode),
      .funct       (funct),
      .zero        (zero),
      .mem_ack     (mem_ack),
      .mem_req     (mem_req),
      .mem_we      (mem_we),
      .pc_en       (pc_en),
      .npc_sel     (npc_sel),
      .ir_en       (ir_en),
      .reg_we      (reg_we),
      .reg_dst     (reg_dst),
      .wd_sel      (wd_sel),
      .alu_src     (alu_src),
      .ext_op      (ext_op),
      .alu_op      (alu_op),
      .illegal     (illegal),
      .state       (state),
      .instr_count (instr_count)
   );

   assign obs = {mem_req, mem_we, pc_en, npc_sel, ir_en, reg_we, reg_dst, wd_sel,
                 alu_src, ext_op, alu_op, illegal, state};

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // One clock cycle: drive inputs, compare outputs mid-cycle, advance past the edge.
   task automatic cyc(input string tag, input logic ack, input logic z, input outs_t e,
                      input outs_t m);
      mem_ack = ack;
      zero    = z;
      #1;
      check_eq({tag, "_out"}, 32'(obs & m), 32'(e & m));
      check_eq({tag, "_cnt"}, instr_count, exp_count);
      @(posedge clk);
      #1;
      cyc_n++;
   endtask

   task automatic do_reset(input string tag);
      reset   = 1'b0;
      mem_ack = 1'($urandom);
      zero    = 1'($urandom);
      #1;
      check_eq({tag, "_rst_out"}, 32'(obs), 32'd0);
      check_eq({tag, "_rst_cnt"}, instr_count, 32'd0);
      @(posedge clk);
      #1;
      reset     = 1'b1;
      exp_count = '0;
   endtask

   task automatic encode(input int k, output logic [5:0] op, output logic [5:0] fn);
      int idx;
      fn = 6'($urandom);
      case (k)
         K_NOP:  begin op = 6'b000000; fn = 6'b000000; end
         K_ADDU: begin op = 6'b000000; fn = 6'b100001; end
         K_SUBU: begin op = 6'b000000; fn = 6'b100011; end
         K_JR:   begin op = 6'b000000; fn = 6'b001000; end
         K_ORI:  op = 6'b001101;
         K_LUI:  op = 6'b001111;
         K_LW:   op = 6'b100011;
         K_SW:   op = 6'b101011;
         K_BEQ:  op = 6'b000100;
         K_JAL:  op = 6'b000011;
         default: begin
            idx = $urandom_range(0, 5);
            op  = ill_op[idx];
            if (op == 6'b000000) fn = ill_fn[idx];
         end
      endcase
   endtask

   // Runs one instruction. fw/mw = wait cycles in FETCH/MEM (mw = trap dwell for
   // illegal). abort = apply reset while the memory access is still pending.
   task automatic run_instr(input int k, input int fw, input int mw, input logic z,
                            input logic abort);
      outs_t e;
      logic [5:0] op, fn;
      opcode = 6'($urandom);
      funct  = 6'($urandom);
      for (int i = 0; i < fw; i++) begin
         e = '0; e.mem_req = 1'b1;
         cyc("fetch_wait", 1'b0, 1'($urandom), e, full_mask);
      end
      e = '0; e.mem_req = 1'b1; e.ir_en = 1'b1; e.pc_en = 1'b1;
      cyc("fetch_ack", 1'b1, 1'($urandom), e, full_mask);

      encode(k, op, fn);
      opcode = op;
      funct  = fn;
      e = '0; e.state = 3'd1;
      cyc("decode", 1'($urandom), 1'($urandom), e, full_mask);
      // IR contents after DECODE must not matter any more
      opcode = 6'($urandom);
      funct  = 6'($urandom);

      e = '0; e.state = 3'd2;
      case (k)
         K_NOP: exp_count++;
         K_ADDU, K_SUBU, K_ORI, K_LUI: begin
            if (k == K_SUBU) e.alu_op = 2'd1;
            if (k == K_ORI) begin e.alu_src = 1'b1; e.alu_op = 2'd2; end
            if (k == K_LUI) begin e.alu_src = 1'b1; e.alu_op = 2'd3; end
            cyc("exec_alu", 1'($urandom), 1'($urandom), e, full_mask);
            e.state   = 3'd4;
            e.reg_we  = 1'b1;
            e.reg_dst = (k == K_ADDU || k == K_SUBU) ? 2'd1 : 2'd0;
            cyc("wb_alu", 1'($urandom), 1'($urandom), e, full_mask);
            exp_count++;
         end
         K_LW, K_SW: begin
            e.alu_src = 1'b1; e.ext_op = 1'b1;
            cyc("exec_mem", 1'($urandom), 1'($urandom), e, full_mask);
            e = '0; e.state = 3'd3; e.mem_req = 1'b1; e.mem_we = (k == K_SW);
            for (int i = 0; i < mw; i++)
               cyc("mem_wait", 1'b0, 1'($urandom), e, mem_mask);
            if (abort) begin
               do_reset("abort");
               return;
            end
            cyc("mem_ack", 1'b1, 1'($urandom), e, mem_mask);
            if (k == K_LW) begin
               e = '0; e.state = 3'd4; e.reg_we = 1'b1; e.wd_sel = 2'd1;
               e.alu_src = 1'b1; e.ext_op = 1'b1;
               cyc("wb_lw", 1'($urandom), 1'($urandom), e, full_mask);
            end
            exp_count++;
         end
         K_BEQ: begin
            e.alu_op = 2'd1; e.npc_sel = 2'd1; e.ext_op = 1'b1; e.pc_en = z;
            cyc("exec_beq", 1'($urandom), z, e, full_mask);
            exp_count++;
         end
         K_JAL: begin
            e.pc_en = 1'b1; e.npc_sel = 2'd2; e.reg_we = 1'b1; e.reg_dst = 2'd2; e.wd_sel = 2'd2;
            cyc("exec_jal", 1'($urandom), 1'($urandom), e, full_mask);
            exp_count++;
         end
         K_JR: begin
            e.pc_en = 1'b1; e.npc_sel = 2'd3;
            cyc("exec_jr", 1'($urandom), 1'($urandom), e, full_mask);
            exp_count++;
         end
         default: begin
            e = '0; e.state = 3'd5; e.illegal = 1'b1;
            for (int i = 0; i < mw; i++)
               cyc("trap", 1'($urandom), 1'($urandom), e, full_mask);
            do_reset("trap");
         end
      endcase
   endtask

   initial begin
      int c0;
      int k;
      ill_op[0] = 6'b111111; ill_fn[0] = 6'b000000;
      ill_op[1] = 6'b000010; ill_fn[1] = 6'b000000;
      ill_op[2] = 6'b001000; ill_fn[2] = 6'b000000;
      ill_op[3] = 6'b000101; ill_fn[3] = 6'b000000;
      ill_op[4] = 6'b000000; ill_fn[4] = 6'b100000;
      ill_op[5] = 6'b000000; ill_fn[5] = 6'b101010;
      full_mask = '1;
      mem_mask  = '1;
      mem_mask.alu_src = 1'b0;
      mem_mask.ext_op  = 1'b0;
      mem_mask.alu_op  = 2'b00;

      reset = 1'b0; opcode = '0; funct = '0; zero = 1'b0; mem_ack = 1'b0;
      exp_count = '0;
      @(posedge clk);
      #1;
      do_reset("init");

      // ADDU with immediate acks: 0,1,2,4 then count = 1
      c0 = cyc_n;
      run_instr(K_ADDU, 0, 0, 1'b0, 1'b0);
      check_eq("addu_cycles", 32'(cyc_n - c0), 32'd4);
      #1;
      check_eq("addu_count", instr_count, 32'd1);

      // LW with two wait cycles in FETCH and MEM: 9 cycles
      c0 = cyc_n;
      run_instr(K_LW, 2, 2, 1'b0, 1'b0);
      check_eq("lw_cycles", 32'(cyc_n - c0), 32'd9);

      // BEQ taken / not taken, 3 cycles each
      c0 = cyc_n;
      run_instr(K_BEQ, 0, 0, 1'b1, 1'b0);
      check_eq("beq_t_cycles", 32'(cyc_n - c0), 32'd3);
      c0 = cyc_n;
      run_instr(K_BEQ, 0, 0, 1'b0, 1'b0);
      check_eq("beq_nt_cycles", 32'(cyc_n - c0), 32'd3);
      check_eq("beq_count", instr_count, 32'd4);

      run_instr(K_JAL, 0, 0, 1'b0, 1'b0);
      run_instr(K_NOP, 1, 0, 1'b0, 1'b0);
      run_instr(K_SW, 0, 1, 1'b0, 1'b0);

      // Opcode 111111: trap for 20 cycles, then a 1-cycle reset
      opcode = 6'b111111;
      run_instr(K_ILL, 0, 20, 1'b0, 1'b0);
      run_instr(K_ORI, 0, 0, 1'b0, 1'b0);

      // SW stalled in MEM, reset aborts it; the next FETCH requests memory again
      run_instr(K_SW, 0, 3, 1'b0, 1'b1);
      run_instr(K_LUI, 0, 0, 1'b0, 1'b0);

      // Randomized instruction stream
      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(0, 99) < 4) k = K_ILL;
         else                           k = $urandom_range(0, 9);
         run_instr(k, $urandom_range(0, 3),
                   (k == K_ILL) ? $urandom_range(1, 5) : $urandom_range(0, 3),
                   1'($urandom), ($urandom_range(0, 99) < 5));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multi-cycle control FSM for the MIPS core. It sequences a single shared datapath (PC, IR, GRF, ALU, EXT, one shared instruction/data memory) through FETCH/DECODE/EXEC/MEM/WB. It takes opcode/funct from the instruction field splitter driven by the IR and the ALU zero flag. It issues every enable and mux select, handshakes with memory, and counts retired instructions.

## Interface
- No parameters.
- `clk` in 1: core clock; all state changes on the rising edge.
- `reset` in 1: synchronous reset, active-low (0 = reset).
- `opcode` in 6: IR[31:26], from the splitter.
- `funct` in 6: IR[5:0], from the splitter.
- `zero` in 1: ALU result == 0.
- `mem_ack` in 1: memory completed the current request this cycle.
- `mem_req` out 1: memory access request, held until `mem_ack`.
- `mem_we` out 1: memory write (sw only; qualifies `mem_req`).
- `pc_en` out 1: PC load.
- `npc_sel` out 2: 0 = PC+4, 1 = branch target, 2 = j-target, 3 = GPR[rs].
- `ir_en` out 1: IR load.
- `reg_we` out 1: GRF write.
- `reg_dst` out 2: 0 = rt, 1 = rd, 2 = $31.
- `wd_sel` out 2: 0 = ALU, 1 = memory data, 2 = PC+4.
- `alu_src` out 1: 0 = GPR[rt], 1 = EXT output.
- `ext_op` out 1: 0 = zero-extend, 1 = sign-extend.
- `alu_op` out 2: 0 = ADD, 1 = SUB, 2 = OR, 3 = LUI (imm<<16).
- `illegal` out 1: sticky; core in TRAP.
- `state` out 3: current state code, for debug.
- `instr_count` out 32: retired instructions.

## Operation
- State codes: FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4, TRAP = 5. Codes 6 and 7 go to TRAP.
- FETCH:
  - `mem_req` = 1, `mem_we` = 0.
  - On `mem_ack`: `ir_en` = 1, `pc_en` = 1, `npc_sel` = 0, then go to DECODE.
  - Without `mem_ack`: stay in FETCH.
- DECODE: the `mc_decode` result is latched into a 4-bit class register. Classes and opcode/funct codes:
  - ADDU: R-type, funct 100001.
  - SUBU: R-type, funct 100011.
  - JR: R-type, funct 001000.
  - NOP: R-type, funct 000000; other fields ignored.
  - ORI: 001101.
  - LUI: 001111.
  - LW: 100011.
  - SW: 101011.
  - BEQ: 000100.
  - JAL: 000011.
  - Anything else: ILLEGAL.
- DECODE transitions:
  - NOP retires and goes to FETCH.
  - ILLEGAL goes to TRAP.
  - All others go to EXEC.
- EXEC (selects driven from the class register):
  - ADDU/SUBU: `alu_src` = 0, `alu_op` = ADD/SUB, then go to WB.
  - ORI: `alu_src` = 1, `ext_op` = 0, `alu_op` = OR, then go to WB.
  - LUI: `alu_src` = 1, `alu_op` = LUI, then go to WB.
  - LW/SW: `alu_src` = 1, `ext_op` = 1, `alu_op` = ADD, then go to MEM.
  - BEQ: `alu_op` = SUB, `npc_sel` = 1, `pc_en` = `zero`, `ext_op` = 1; retires and goes to FETCH.
  - JAL: `pc_en` = 1, `npc_sel` = 2, `reg_we` = 1, `reg_dst` = 2, `wd_sel` = 2; retires and goes to FETCH.
  - JR: `pc_en` = 1, `npc_sel` = 3; retires and goes to FETCH.
- MEM:
  - `mem_req` = 1; `mem_we` = 1 for SW.
  - Without `mem_ack`: stay in MEM with outputs unchanged.
  - On `mem_ack`: LW goes to WB; SW retires and goes to FETCH.
- WB:
  - `reg_we` = 1; retires and goes to FETCH.
  - ADDU/SUBU: `reg_dst` = 1, `wd_sel` = 0.
  - ORI/LUI: `reg_dst` = 0, `wd_sel` = 0.
  - LW: `reg_dst` = 0, `wd_sel` = 1.
  - ALU selects are held from EXEC.
- TRAP: `illegal` = 1; all enables and `mem_req` = 0. Only reset leaves TRAP.
- Retire: `instr_count` += 1 on the edge that leaves the instruction's final state. It wraps modulo 2^32.
- Unlisted outputs are 0 in every state.
- Output path: outputs are combinational from the state and class registers. The only exceptions are `pc_en` (depends on `zero` in EXEC for BEQ) and `pc_en`/`ir_en` (depend on `mem_ack` in FETCH).

## Timing
- Reset (`reset` = 0 at an edge):
  - State = FETCH, class = NOP, `instr_count` = 0.
  - While `reset` = 0, every output is forced to 0 except `state` = 0. This includes `mem_req`.
  - Reset overrides any in-flight access, including MEM with `mem_we` = 1. The aborted instruction is not counted.
- Cycle counts with `mem_ack` = 1 in the first request cycle:
  - NOP: 2 cycles.
  - BEQ, JAL, JR: 3 cycles.
  - ADDU, SUBU, ORI, LUI, SW: 4 cycles.
  - LW: 5 cycles.
  - Each extra wait cycle in FETCH or MEM adds 1.
- `mem_ack` outside FETCH and MEM is ignored.
- `mem_req` never drops before the acknowledging cycle.

## Structure
- Package `mc_ctrl_pkg` holds:
  - The state enum and class enum.
  - Opcode and funct constants.
  - Encodings for `npc_sel`, `reg_dst`, `wd_sel` and `alu_op`.
- Sub-module `mc_decode`: purely combinational, maps opcode/funct to the class enum. It is reusable by a later pipelined decoder.
- The FSM, class register and retire counter live in `mc_ctrl`.

## Test plan
- ADDU (opcode 0, funct 100001), `mem_ack` tied to 1:
  - `state` goes 0, 1, 2, 4, 0.
  - `reg_we` = 1 with `reg_dst` = 1 only in cycle 4.
  - `instr_count` = 1 after that cycle.
- LW (100011) with `mem_ack` delayed 2 cycles in both FETCH and MEM:
  - Takes 9 cycles; `mem_req` holds steady.
  - `wd_sel` = 1 in WB.
  - `mem_we` = 0 throughout.
- BEQ with `zero` = 1, then again with `zero` = 0:
  - EXEC shows `pc_en` = 1 / `npc_sel` = 1 in the first case, `pc_en` = 0 in the second.
  - Both take 3 cycles and each increments the count.
- JAL (000011):
  - EXEC asserts `pc_en`, `npc_sel` = 2, `reg_we`, `reg_dst` = 2 and `wd_sel` = 2 in the same cycle.
- Opcode 111111:
  - DECODE leads to TRAP: `illegal` = 1, `mem_req` = 0, held for 20 cycles with `instr_count` unchanged.
  - `reset` = 0 for 1 cycle gives `state` = 0 and `illegal` = 0.
- SW with `mem_ack` held 0 in MEM, then `reset` = 0:
  - The next cycle shows `mem_we` = 0, `mem_req` = 0 and `instr_count` = 0.
  - After release, FETCH asserts `mem_req`.
